serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder for two WIDTH-bit operands, processed LSB first at one bit per cycle.
- The per-bit full-adder slice is built from two half_adder instances (ports a_i, b_i, s_o, c_o) plus an OR gate for the carry.
- The carry is held in a flip-flop between bits.
- Operands enter through a valid/ready handshake; the result leaves through a valid/ready handshake.

Parameters:
WIDTH, 8, operand and sum width in bits (WIDTH >= 2)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
a_i  input  WIDTH  operand A, sampled on input handshake
b_i  input  WIDTH  operand B, sampled on input handshake
cin_i  input  1  carry-in, sampled on input handshake
valid_i  input  1  upstream offers operands
ready_o  output  1  block can accept operands
sum_o  output  WIDTH  result sum, stable while valid_o=1
cout_o  output  1  result carry-out, stable while valid_o=1
valid_o  output  1  result available
ready_i  input  1  downstream accepts result

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - State is IDLE; ready_o=1, valid_o=0.
  - sum_o=0, cout_o=0.
  - Shift registers, carry register and bit counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i=1 (input handshake): load a_sh<=a_i, b_sh<=b_i, carry<=cin_i, cnt<=0; go to RUN.
- RUN:
  - ready_o=0; valid_i is ignored.
  - Each edge: s = a_sh[0]^b_sh[0]^carry; carry <= (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
  - a_sh and b_sh shift right by 1. sum_sh shifts right with s inserted at the MSB. cnt++.
  - On the edge where cnt==WIDTH-1 (the last bit): go to DONE and register sum_o, cout_o from the final values.
- DONE:
  - valid_o=1; sum_o and cout_o held.
  - On ready_i=1 (output handshake): valid_o<=0, go to IDLE.
  - While ready_i=0: hold indefinitely with all outputs unchanged.
- Latency:
  - valid_o rises exactly WIDTH cycles after the input-handshake edge.
  - Minimum issue interval is WIDTH+2 cycles; no overlap of consecutive operations.
- Arithmetic: {cout_o, sum_o} == a_i + b_i + cin_i (unsigned, WIDTH+1 bits). Wrap-around, e.g. 0xFF+0x01, yields sum 0 with cout 1.
- Output stability: sum_o and cout_o change only on the RUN→DONE edge or on reset; they do not toggle during RUN.
- Simultaneous events:
  - valid_i high in DONE is not accepted (ready_o=0 there).
  - ready_i high outside DONE has no effect.
- Reset mid-operation:
  - The in-flight operation is discarded and the state returns to IDLE on that edge.
  - valid_o never asserts for the discarded operation; all outputs take their reset values.
- Counter width: $clog2(WIDTH) bits.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port overflow_o (1 bit): signed overflow = carry into MSB XOR carry out of MSB.
  - The carry into the MSB is captured during the last RUN cycle.
  - overflow_o is registered alongside sum_o and held with it; reset value 0.
- Not defined: port overflow_o and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: rst_i=1 for 2 cycles, then 0 -> ready_o=1, valid_o=0, sum_o=0x00, cout_o=0.
2. WIDTH=8, a=0x05, b=0x03, cin=0 -> valid_o rises exactly 8 cycles after accept; sum_o=0x08, cout_o=0.
3. Carry and overflow:
   - a=0xFF, b=0x01, cin=0 -> sum_o=0x00, cout_o=1 (overflow_o=0 with OVF_EN).
   - a=0x7F, b=0x01 -> sum_o=0x80, cout_o=0 (overflow_o=1 with OVF_EN).
4. Backpressure and ignored inputs:
   - Hold ready_i=0 for 5 cycles in DONE -> valid_o=1 and sum_o unchanged throughout; pulse ready_i -> IDLE next cycle.
   - Toggle valid_i during RUN -> ready_o=0, no new load occurs.
5. Reset mid-RUN: assert rst_i with cnt=3 -> IDLE next edge, valid_o stays 0 for that op; the following op a=0x10, b=0x20 -> sum_o=0x30.
6. Exhaustive at WIDTH=2: all 32 combinations of a, b, cin -> {cout_o, sum_o} == a+b+cin; every result appears 2 cycles after accept.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: two WIDTH-bit operands added LSB first, one bit per clock,
// with valid/ready handshakes on both sides. Define SERIAL_ADDER_OVF_EN to add overflow_o.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             valid_o,
    input  logic             ready_i
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow_o
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-2:0] sum_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic             hs_s;
    logic             hc_s;
    logic             bit_sum_s;
    logic             bit_carry_s;
    logic             carry_nxt_s;
    logic [WIDTH-1:0] sum_nxt_s;

    // Full-adder slice: two half adders, OR merges their carries.
    half_adder u_ha0 (
        .a_i (a_sh_r[0]),
        .b_i (b_sh_r[0]),
        .s_o (hs_s),
        .c_o (hc_s)
    );

    half_adder u_ha1 (
        .a_i (hs_s),
        .b_i (carry_r),
        .s_o (bit_sum_s),
        .c_o (bit_carry_s)
    );

    assign carry_nxt_s = hc_s | bit_carry_s;
    // Bit 0 of the next sum image only ever feeds sum_o, so the register keeps WIDTH-1 bits.
    assign sum_nxt_s   = {bit_sum_s, sum_sh_r};

    // Control FSM, datapath shift registers and registered result outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            sum_o      <= '0;
            cout_o     <= 1'b0;
            a_sh_r     <= '0;
            b_sh_r     <= '0;
            sum_sh_r   <= '0;
            carry_r    <= 1'b0;
            cnt_r      <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow_o <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        a_sh_r  <= a_i;
                        b_sh_r  <= b_i;
                        carry_r <= cin_i;
                        cnt_r   <= '0;
                        ready_o <= 1'b0;
                        state_r <= RUN;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    sum_sh_r <= sum_nxt_s[WIDTH-1:1];
                    carry_r  <= carry_nxt_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_BIT) begin
                        sum_o      <= sum_nxt_s;
                        cout_o     <= carry_nxt_s;
                        valid_o    <= 1'b1;
                        state_r    <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_r is the carry into the MSB during the last bit.
                        overflow_o <= carry_r ^ carry_nxt_s;
`endif
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, random vectors against an
// arithmetic model, backpressure, ignored inputs, mid-run reset and exhaustive WIDTH=2.

module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a8, b8, sum8;
    logic       cin8, valid8, ready8, cout8, vo8, ri8, ovf8;
    logic [1:0] a2, b2, sum2;
    logic       cin2, valid2, ready2, cout2, vo2, ri2, ovf2;

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8), .cin_i(cin8),
        .valid_i(valid8), .ready_o(ready8), .sum_o(sum8), .cout_o(cout8),
        .valid_o(vo8), .ready_i(ri8)
`ifdef SERIAL_ADDER_OVF_EN
        , .overflow_o(ovf8)
`endif
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .a_i(a2), .b_i(b2), .cin_i(cin2),
        .valid_i(valid2), .ready_o(ready2), .sum_o(sum2), .cout_o(cout2),
        .valid_o(vo2), .ready_i(ri2)
`ifdef SERIAL_ADDER_OVF_EN
        , .overflow_o(ovf2)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic on the operands.
    task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output logic [7:0] s, output logic co, output logic ov);
        int total, sa, sb, st;
        total = int'(a) + int'(b) + int'(cin);
        s  = total[7:0];
        co = total[8];
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        st = sa + sb + int'(cin);
        ov = (st > 127) || (st < -128);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input int hold, input bit poke,
                        output logic [7:0] s, output logic co, output logic ov, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; valid8 = 1'b1; ri8 = 1'b0;
        chk("ready_before_accept", {31'd0, ready8}, 32'd1);
        @(negedge clk);
        valid8 = 1'b0;
        lat = 0;
        while (!vo8 && lat < 40) begin
            if (poke) begin
                chk("ready_low_in_run", {31'd0, ready8}, 32'd0);
                valid8 = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        valid8 = 1'b0;
        s = sum8; co = cout8; ov = ovf8;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, vo8}, 32'd1);
            chk("hold_sum", {23'd0, cout8, sum8}, {23'd0, co, s});
        end
        ri8 = 1'b1;
        @(negedge clk);
        ri8 = 1'b0;
        chk("release_to_idle", {30'd0, vo8, ready8}, 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] s, es;
        logic       co, ov, eco, eov, saw;
        int         lat;
        logic [2:0] exp2;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        rst = 1'b1;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; valid8 = 1'b0; ri8 = 1'b0;
        a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0; valid2 = 1'b0; ri2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, ready8}, 32'd1);
        chk("reset_valid", {31'd0, vo8}, 32'd0);
        chk("reset_sum", {23'd0, cout8, sum8}, 32'd0);
        chk("reset_ovf", {31'd0, ovf8}, 32'd0);

        foreach (vecs[i]) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, (i == 0) ? 5 : 0, 1'b0, s, co, ov, lat);
            chk("table_latency", lat, 32'd8);
            chk("table_sum", {23'd0, co, s}, {23'd0, vecs[i].cout, vecs[i].sum});
`ifdef SERIAL_ADDER_OVF_EN
            chk("table_ovf", {31'd0, ov}, {31'd0, vecs[i].ovf});
`endif
        end

        for (int r = 0; r < 20; r++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            model8(ra, rb, rc, es, eco, eov);
            run8(ra, rb, rc, int'($urandom_range(0, 3)), (r % 4) == 1, s, co, ov, lat);
            chk("rand_latency", lat, 32'd8);
            chk("rand_sum", {23'd0, co, s}, {23'd0, eco, es});
`ifdef SERIAL_ADDER_OVF_EN
            chk("rand_ovf", {31'd0, ov}, {31'd0, eov});
`endif
        end

        // Abort an operation after three bits have been processed.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'd0, ready8}, 32'd1);
        chk("midrst_valid", {31'd0, vo8}, 32'd0);
        chk("midrst_sum", {23'd0, cout8, sum8}, 32'd0);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (vo8) saw = 1'b1;
        end
        chk("midrst_no_valid", {31'd0, saw}, 32'd0);
        run8(8'h10, 8'h20, 1'b0, 0, 1'b0, s, co, ov, lat);
        chk("after_rst_sum", {23'd0, co, s}, {23'd0, 1'b0, 8'h30});

        for (int v = 0; v < 32; v++) begin
            logic [4:0] vv;
            vv = 5'(v);
            exp2 = 3'(vv[4:3]) + 3'(vv[2:1]) + 3'(vv[0]);
            @(negedge clk);
            a2 = vv[4:3]; b2 = vv[2:1]; cin2 = vv[0]; valid2 = 1'b1; ri2 = 1'b0;
            @(negedge clk);
            valid2 = 1'b0;
            lat = 0;
            while (!vo2 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("w2_latency", lat, 32'd2);
            chk("w2_sum", {29'd0, cout2, sum2}, {29'd0, exp2});
            ri2 = 1'b1;
            @(negedge clk);
            ri2 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
